// File: rtl/mcp3201_sampler_if.sv
// ============================================================================
// Module      : mcp3201_sampler_if
// Description : Pin/bus bundle between the dual-MCP3201 transaction
//               controller and its surroundings.
//   start     : request one conversion frame (sampled only when idle)
//   auto_run  : free-running frames while high
//   miso_a/b  : ADC data lines, asynchronous to the system clock
//   cs_n      : shared chip select, active low
//   sclk      : shared SPI clock, idle low
//   data_a/b  : last captured 12-bit conversions
//   valid     : one-cycle strobe when data/err update
//   err_a/b   : null bit read as 1 on that channel in the last frame
//   busy      : frame in progress (acceptance through end of gap)
// Modports    : master = sampler side, slave = user/ADC side
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface mcp3201_sampler_if;
  logic        start;
  logic        auto_run;
  logic        miso_a;
  logic        miso_b;
  logic        cs_n;
  logic        sclk;
  logic [11:0] data_a;
  logic [11:0] data_b;
  logic        valid;
  logic        err_a;
  logic        err_b;
  logic        busy;

  modport master (
    input  start, auto_run, miso_a, miso_b,
    output cs_n, sclk, data_a, data_b, valid, err_a, err_b, busy
  );

  modport slave (
    output start, auto_run, miso_a, miso_b,
    input  cs_n, sclk, data_a, data_b, valid, err_a, err_b, busy
  );
endinterface

`default_nettype wire

// File: rtl/mcp3201_sampler.sv
// ============================================================================
// Module      : mcp3201_sampler
// Description : Frame controller for two MCP3201 ADCs sharing cs_n and sclk.
//               Generates sclk from the system clock (rounded-period divider,
//               half period HPER), runs IDLE/SETUP/SHIFT/GAP, synchronises
//               both MISO lines and deserialises two 12-bit results in
//               parallel, flagging a null bit read as 1.
// Ports       : clock   - system clock, rising edge
//               reset_n - asynchronous active-low reset
//               bus     - mcp3201_sampler_if.master (control, ADC pins,
//                         results, valid/busy)
// Parameters  : CLOCK_FREQ - system clock in Hz
//               SCLK_FREQ  - target SPI clock in Hz
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module mcp3201_sampler #(
  parameter int CLOCK_FREQ = 12000000,
  parameter int SCLK_FREQ  = 1000000
) (
  input  logic              clock,
  input  logic              reset_n,
  mcp3201_sampler_if.master bus
);

  // PERIOD = floor(CLOCK_FREQ/SCLK_FREQ + 0.5), done in 64-bit integer math
  localparam longint PERIOD = (2 * longint'(CLOCK_FREQ) + longint'(SCLK_FREQ))
                              / (2 * longint'(SCLK_FREQ));
  localparam int     HPER   = int'(PERIOD / 2);
  localparam int     CW     = $clog2(2 * HPER);
  localparam logic [CW-1:0] HPER_M1 = CW'(HPER - 1);
  localparam logic [CW-1:0] GAP_M1  = CW'(2 * HPER - 1);

  generate
    if (HPER < 3) begin : g_hper_too_small
      $error("mcp3201_sampler: SCLK half period below 3 system clocks");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_SHIFT = 2'd2,
    ST_GAP   = 2'd3
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [3:0]    bit_idx;
  logic          cs_n_r;
  logic          sclk_r;
  logic          busy_r;
  logic          valid_r;
  logic [11:0]   data_a_r;
  logic [11:0]   data_b_r;
  logic          err_a_r;
  logic          err_b_r;
  // Bits 4..14 accumulate here; bit 15 is taken straight from the
  // synchroniser on the final edge.
  logic [10:0]   sh_a;
  logic [10:0]   sh_b;
  logic          err_pend_a;
  logic          err_pend_b;
  logic          sync1_a;
  logic          sync2_a;
  logic          sync1_b;
  logic          sync2_b;

  // Two-stage synchronisers on the asynchronous MISO lines
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1_a <= 1'b0;
      sync2_a <= 1'b0;
      sync1_b <= 1'b0;
      sync2_b <= 1'b0;
    end else begin
      sync1_a <= bus.miso_a;
      sync2_a <= sync1_a;
      sync1_b <= bus.miso_b;
      sync2_b <= sync1_b;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      bit_idx    <= 4'd0;
      cs_n_r     <= 1'b1;
      sclk_r     <= 1'b0;
      busy_r     <= 1'b0;
      valid_r    <= 1'b0;
      data_a_r   <= 12'd0;
      data_b_r   <= 12'd0;
      err_a_r    <= 1'b0;
      err_b_r    <= 1'b0;
      sh_a       <= 11'd0;
      sh_b       <= 11'd0;
      err_pend_a <= 1'b0;
      err_pend_b <= 1'b0;
    end else begin
      valid_r <= 1'b0;
      case (state)
        ST_IDLE: begin
          cs_n_r <= 1'b1;
          sclk_r <= 1'b0;
          busy_r <= 1'b0;
          cnt    <= '0;
          if (bus.start || bus.auto_run) begin
            state  <= ST_SETUP;
            cs_n_r <= 1'b0;
            busy_r <= 1'b1;
          end
        end

        ST_SETUP: begin
          if (cnt == HPER_M1) begin
            cnt     <= '0;
            sclk_r  <= 1'b1;
            bit_idx <= 4'd1;
            state   <= ST_SHIFT;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        ST_SHIFT: begin
          if (cnt == HPER_M1) begin
            cnt <= '0;
            if (sclk_r) begin
              // End of a high phase: falling edge and sample point
              sclk_r <= 1'b0;
              if (bit_idx == 4'd3) begin
                err_pend_a <= sync2_a;
                err_pend_b <= sync2_b;
              end else if (bit_idx >= 4'd4 && bit_idx <= 4'd14) begin
                sh_a <= {sh_a[9:0], sync2_a};
                sh_b <= {sh_b[9:0], sync2_b};
              end
              if (bit_idx == 4'd15) begin
                cs_n_r   <= 1'b1;
                data_a_r <= {sh_a, sync2_a};
                data_b_r <= {sh_b, sync2_b};
                err_a_r  <= err_pend_a;
                err_b_r  <= err_pend_b;
                valid_r  <= 1'b1;
                state    <= ST_GAP;
              end
            end else begin
              // End of a low phase: next bit starts
              sclk_r  <= 1'b1;
              bit_idx <= bit_idx + 4'd1;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        ST_GAP: begin
          if (cnt == GAP_M1) begin
            cnt <= '0;
            if (bus.auto_run) begin
              state  <= ST_SETUP;
              cs_n_r <= 1'b0;
            end else begin
              state  <= ST_IDLE;
              busy_r <= 1'b0;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        default: begin
          state  <= ST_IDLE;
          cs_n_r <= 1'b1;
          sclk_r <= 1'b0;
          busy_r <= 1'b0;
          cnt    <= '0;
        end
      endcase
    end
  end

  assign bus.cs_n   = cs_n_r;
  assign bus.sclk   = sclk_r;
  assign bus.busy   = busy_r;
  assign bus.valid  = valid_r;
  assign bus.data_a = data_a_r;
  assign bus.data_b = data_b_r;
  assign bus.err_a  = err_a_r;
  assign bus.err_b  = err_b_r;

endmodule

`default_nettype wire

// File: tb/tb_mcp3201_sampler.sv
// ============================================================================
// Module      : tb_mcp3201_sampler
// Description : Self-checking bench for mcp3201_sampler. Two instances:
//               default rates (HPER=6) and 12 MHz / 1.7 MHz (HPER=3).
//               A behavioural MCP3201 pair drives MISO from sclk falls;
//               expected conversions are queued when a frame is launched
//               and compared when valid strobes.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_mcp3201_sampler;

  localparam int H0 = 6;
  localparam int H1 = 3;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  int   total   = 0;
  int   bad     = 0;
  int   cyc     = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  mcp3201_sampler_if bus0 ();
  mcp3201_sampler_if bus1 ();

  logic [1:0] st;
  logic [1:0] ar;
  logic [1:0] ma;
  logic [1:0] mb;

  assign bus0.start    = st[0];
  assign bus0.auto_run = ar[0];
  assign bus0.miso_a   = ma[0];
  assign bus0.miso_b   = mb[0];
  assign bus1.start    = st[1];
  assign bus1.auto_run = ar[1];
  assign bus1.miso_a   = ma[1];
  assign bus1.miso_b   = mb[1];

  mcp3201_sampler #(.CLOCK_FREQ(12000000), .SCLK_FREQ(1000000)) dut0 (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus0)
  );

  mcp3201_sampler #(.CLOCK_FREQ(12000000), .SCLK_FREQ(1700000)) dut1 (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus1)
  );

  typedef struct packed {
    logic [11:0] a;
    logic [11:0] b;
    logic        ea;
    logic        eb;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  // ADC model settings and monitor state, per instance
  logic [11:0] adc_a [2];
  logic [11:0] adc_b [2];
  logic [1:0]  nul_a;
  logic [1:0]  nul_b;
  int e0 [2];
  int pulses [2];
  int edge_err [2];
  int falls [2];
  int last_rise [2];
  int cs_hi [2];
  int vcnt [2];
  int vtime [2];
  int vprev [2];
  logic [1:0] p_cs = 2'b11;
  logic [1:0] p_sk = 2'b00;
  logic [1:0] p_v  = 2'b00;
  logic [1:0] p_bz = 2'b00;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // MCP3201 output bit k (1-based, as clocked out): two sample-window
  // bits (driven 1 so a design that keeps them would be caught), null, B11..B0
  function automatic logic bitval(logic [11:0] d, logic nb, int k);
    if (k <= 2)  return 1'b1;
    if (k == 3)  return nb;
    if (k <= 15) return d[15 - k];
    return 1'b0;
  endfunction

  // Monitor + ADC model, evaluated on the falling system-clock edge
  always @(negedge clock) begin
    logic [1:0]  cs, sk, v, bz;
    logic [11:0] da, db;
    logic        ea, eb;
    exp_t        e;
    logic        have;
    int          h;
    cs = {bus1.cs_n,  bus0.cs_n};
    sk = {bus1.sclk,  bus0.sclk};
    v  = {bus1.valid, bus0.valid};
    bz = {bus1.busy,  bus0.busy};
    if (reset_n) begin
      for (int i = 0; i < 2; i++) begin
        h  = (i == 0) ? H0 : H1;
        da = (i == 0) ? bus0.data_a : bus1.data_a;
        db = (i == 0) ? bus0.data_b : bus1.data_b;
        ea = (i == 0) ? bus0.err_a  : bus1.err_a;
        eb = (i == 0) ? bus0.err_b  : bus1.err_b;
        if (p_cs[i] && !cs[i]) begin
          cs_hi[i]    = cyc - last_rise[i];
          e0[i]       = cyc;
          pulses[i]   = 0;
          edge_err[i] = 0;
          falls[i]++;
          ma[i] = bitval(adc_a[i], nul_a[i], 1);
          mb[i] = bitval(adc_b[i], nul_b[i], 1);
        end
        if (!p_cs[i] && cs[i]) last_rise[i] = cyc;
        if (!p_sk[i] && sk[i]) begin
          pulses[i]++;
          if (cyc != e0[i] + h + (pulses[i] - 1) * 2 * h) edge_err[i]++;
        end
        if (p_sk[i] && !sk[i]) begin
          if (cyc != e0[i] + 2 * pulses[i] * h) edge_err[i]++;
          ma[i] = bitval(adc_a[i], nul_a[i], pulses[i] + 1);
          mb[i] = bitval(adc_b[i], nul_b[i], pulses[i] + 1);
        end
        if (p_v[i]) check($sformatf("dut%0d_valid_one_cycle", i), v[i], 0);
        if (v[i]) begin
          vcnt[i]++;
          vprev[i] = vtime[i];
          vtime[i] = cyc;
          check($sformatf("dut%0d_valid_time", i), cyc - e0[i], 30 * h);
          check($sformatf("dut%0d_sclk_pulses", i), pulses[i], 15);
          check($sformatf("dut%0d_sclk_edge_timing_errs", i), edge_err[i], 0);
          check($sformatf("dut%0d_cs_high_at_valid", i), cs[i], 1);
          have = (i == 0) ? (q0.size() > 0) : (q1.size() > 0);
          check($sformatf("dut%0d_valid_expected", i), have, 1);
          if (have) begin
            e = (i == 0) ? q0.pop_front() : q1.pop_front();
            check($sformatf("dut%0d_data_a", i), da, e.a);
            check($sformatf("dut%0d_data_b", i), db, e.b);
            check($sformatf("dut%0d_err_a", i), ea, e.ea);
            check($sformatf("dut%0d_err_b", i), eb, e.eb);
          end
        end
        if (p_bz[i] && !bz[i])
          check($sformatf("dut%0d_busy_fall_time", i), cyc - e0[i], 32 * h);
      end
    end
    p_cs = cs;
    p_sk = sk;
    p_v  = v;
    p_bz = bz;
  end

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic pulse_start(int i);
    st[i] = 1'b1;
    tick();
    st[i] = 1'b0;
  endtask

  task automatic set_adc(int i, logic [11:0] a, logic na, logic [11:0] b, logic nb);
    adc_a[i] = a;
    nul_a[i] = na;
    adc_b[i] = b;
    nul_b[i] = nb;
  endtask

  task automatic push(int i, logic [11:0] a, logic [11:0] b, logic ea, logic eb);
    exp_t e;
    e.a = a; e.b = b; e.ea = ea; e.eb = eb;
    if (i == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  function automatic logic busy_of(int i);
    return (i == 0) ? bus0.busy : bus1.busy;
  endfunction

  task automatic wait_idle(int i, int bound);
    int n = 0;
    while (busy_of(i) !== 1'b0 && n < bound) begin
      tick();
      n++;
    end
    check($sformatf("dut%0d_idle_within_bound", i), busy_of(i), 0);
  endtask

  task automatic wait_falls(int i, int target, int bound);
    int n = 0;
    while (falls[i] < target && n < bound) begin
      tick();
      n++;
    end
    check($sformatf("dut%0d_cs_fall_within_bound", i), falls[i] >= target, 1);
  endtask

  task automatic wait_cyc(int target);
    while (cyc < target) tick();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int f, t1, vc;
    st = 2'b00; ar = 2'b00; ma = 2'b00; mb = 2'b00;
    nul_a = 2'b00; nul_b = 2'b00;
    for (int i = 0; i < 2; i++) begin
      adc_a[i] = 12'd0; adc_b[i] = 12'd0;
      e0[i] = 0; pulses[i] = 0; edge_err[i] = 0; falls[i] = 0;
      last_rise[i] = 0; cs_hi[i] = 0; vcnt[i] = 0; vtime[i] = 0; vprev[i] = 0;
    end
    reset_n = 1'b0;
    repeat (3) tick();

    // Reset state
    check("rst_cs_n",   bus0.cs_n,   1);
    check("rst_sclk",   bus0.sclk,   0);
    check("rst_busy",   bus0.busy,   0);
    check("rst_valid",  bus0.valid,  0);
    check("rst_data_a", bus0.data_a, 0);
    check("rst_data_b", bus0.data_b, 0);
    check("rst_err_a",  bus0.err_a,  0);
    check("rst_err_b",  bus0.err_b,  0);
    check("rst1_cs_n",  bus1.cs_n,   1);
    reset_n = 1'b1;
    tick();

    // Basic frame
    set_adc(0, 12'hA5C, 1'b0, 12'h3F1, 1'b0);
    push(0, 12'hA5C, 12'h3F1, 1'b0, 1'b0);
    pulse_start(0);
    wait_idle(0, 400);
    check("hold_data_a", bus0.data_a, 12'hA5C);

    // Null bit error on A, all-zero B
    set_adc(0, 12'hFFF, 1'b1, 12'h000, 1'b0);
    push(0, 12'hFFF, 12'h000, 1'b1, 1'b0);
    pulse_start(0);
    wait_idle(0, 400);
    check("hold_err_a", bus0.err_a, 1);

    // Clean frame clears err_a
    set_adc(0, 12'h123, 1'b0, 12'hABC, 1'b0);
    push(0, 12'h123, 12'hABC, 1'b0, 1'b0);
    pulse_start(0);
    wait_idle(0, 400);
    check("err_a_cleared", bus0.err_a, 0);

    // start while busy is ignored
    set_adc(0, 12'h456, 1'b0, 12'h789, 1'b1);
    push(0, 12'h456, 12'h789, 1'b0, 1'b1);
    f = falls[0];
    pulse_start(0);
    wait_cyc(e0[0] + 49);
    pulse_start(0);                 // sampled at E0+50
    wait_cyc(e0[0] + 189);
    pulse_start(0);                 // sampled at E0+190
    wait_idle(0, 400);
    repeat (20) tick();
    check("no_second_frame", falls[0], f + 1);
    check("idle_cs_n", bus0.cs_n, 1);

    // Free-running for three frames
    set_adc(0, 12'h5A5, 1'b0, 12'h0F0, 1'b0);
    repeat (3) push(0, 12'h5A5, 12'h0F0, 1'b0, 1'b0);
    f  = falls[0];
    vc = vcnt[0];
    ar[0] = 1'b1;
    wait_falls(0, f + 1, 50);
    t1 = e0[0];
    wait_falls(0, f + 2, 400);
    check("auto_cs_period_1", e0[0] - t1, 32 * H0);
    check("auto_cs_high_1", cs_hi[0], 2 * H0);
    t1 = e0[0];
    wait_falls(0, f + 3, 400);
    check("auto_cs_period_2", e0[0] - t1, 32 * H0);
    check("auto_cs_high_2", cs_hi[0], 2 * H0);
    check("auto_valid_spacing_1", vtime[0] - vprev[0], 32 * H0);
    ar[0] = 1'b0;
    wait_idle(0, 400);
    check("auto_valid_count", vcnt[0] - vc, 3);
    check("auto_valid_spacing_2", vtime[0] - vprev[0], 32 * H0);
    check("auto_stops", falls[0], f + 3);

    // Reset mid-frame, while sclk is high (bit 9 high phase)
    set_adc(0, 12'hFED, 1'b0, 12'h0CB, 1'b0);
    vc = vcnt[0];
    pulse_start(0);
    wait_cyc(e0[0] + 102);
    check("pre_reset_sclk", bus0.sclk, 1);
    reset_n = 1'b0;
    #1;
    check("abort_cs_n",   bus0.cs_n,   1);
    check("abort_sclk",   bus0.sclk,   0);
    check("abort_busy",   bus0.busy,   0);
    check("abort_valid",  bus0.valid,  0);
    check("abort_data_a", bus0.data_a, 0);
    check("abort_data_b", bus0.data_b, 0);
    repeat (3) tick();
    reset_n = 1'b1;
    tick();
    repeat (400) tick();
    check("abort_no_valid", vcnt[0], vc);
    set_adc(0, 12'h7E1, 1'b0, 12'h18F, 1'b1);
    push(0, 12'h7E1, 12'h18F, 1'b0, 1'b1);
    pulse_start(0);
    wait_idle(0, 400);

    // HPER=3 instance
    set_adc(1, 12'h9C3, 1'b0, 12'h16E, 1'b0);
    push(1, 12'h9C3, 12'h16E, 1'b0, 1'b0);
    pulse_start(1);
    wait_idle(1, 200);
    set_adc(1, 12'h0AB, 1'b1, 12'hF00, 1'b0);
    push(1, 12'h0AB, 12'hF00, 1'b1, 1'b0);
    pulse_start(1);
    wait_idle(1, 200);

    check("queue0_drained", q0.size(), 0);
    check("queue1_drained", q1.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
